// File: rtl/vdp_scandbl_pkg.sv
// Shared constants and types for the scan-doubler line buffers.
// VDP_SCANDBL_FULL_DEPTH_EN: store all colour bits; otherwise the colour LSB is dropped (YJK-sufficient).
package vdp_scandbl_pkg;
    localparam int DEF_LINE_WIDTH = 640;
    localparam int DEF_ADDR_W     = 10;
    localparam int COLOR_W        = 6;
`ifdef VDP_SCANDBL_FULL_DEPTH_EN
    localparam int STORE_W        = COLOR_W;
`else
    localparam int STORE_W        = COLOR_W - 1;
`endif

    typedef logic                bank_sel_t;
    typedef logic [COLOR_W-1:0]  color_t;
    typedef logic [STORE_W-1:0]  store_t;

    function automatic store_t pack_color(input color_t c);
        return c[COLOR_W-1 -: STORE_W];
    endfunction

    // Dropped LSBs come back as zero.
    function automatic color_t unpack_color(input store_t s);
        color_t c;
        c = '0;
        c[COLOR_W-1 -: STORE_W] = s;
        return c;
    endfunction
endpackage

// File: rtl/vdp_scandbl_ctrl_if.sv
// Pixel write/read strobes and colour buses between the VDP, the scan doubler and the VGA stage.
interface vdp_scandbl_ctrl_if;
    import vdp_scandbl_pkg::*;

    logic   WR_START;
    logic   WR_EN;
    color_t DATA_R;
    color_t DATA_G;
    color_t DATA_B;
    logic   RD_START;
    logic   RD_EN;
    color_t Q_R;
    color_t Q_G;
    color_t Q_B;
    logic   Q_VALID;
    logic   WR_OVF;

    modport master (
        output WR_START, WR_EN, DATA_R, DATA_G, DATA_B, RD_START, RD_EN,
        input  Q_R, Q_G, Q_B, Q_VALID, WR_OVF
    );

    modport slave (
        input  WR_START, WR_EN, DATA_R, DATA_G, DATA_B, RD_START, RD_EN,
        output Q_R, Q_G, Q_B, Q_VALID, WR_OVF
    );
endinterface

// File: rtl/vdp_scandbl_bank.sv
// One line bank: three colour RAMs with a write port and a registered read address.
// Read data follows the address latched on the previous edge; no backpressure.
module vdp_scandbl_bank
    import vdp_scandbl_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  store_t            i_wr_r,
    input  store_t            i_wr_g,
    input  store_t            i_wr_b,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output store_t            o_rd_r,
    output store_t            o_rd_g,
    output store_t            o_rd_b
);
    store_t            r_mem_r [LINE_WIDTH];
    store_t            r_mem_g [LINE_WIDTH];
    store_t            r_mem_b [LINE_WIDTH];
    logic [ADDR_W-1:0] r_rd_addr;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem_r[i_wr_addr] <= i_wr_r;
            r_mem_g[i_wr_addr] <= i_wr_g;
            r_mem_b[i_wr_addr] <= i_wr_b;
        end
        if (i_re) begin
            r_rd_addr <= i_rd_addr;
        end
    end

    assign o_rd_r = r_mem_r[r_rd_addr];
    assign o_rd_g = r_mem_g[r_rd_addr];
    assign o_rd_b = r_mem_b[r_rd_addr];
endmodule

// File: rtl/vdp_scandbl_ctrl.sv
// Ping-pong line buffer: capture one source line per bank, replay the other bank on two VGA lines.
// Latency: Q 2 cycles after accepted RD_EN; no backpressure (over-range pixels dropped, WR_OVF sticky).
module vdp_scandbl_ctrl
    import vdp_scandbl_pkg::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic              CLK21M,
    input  logic              RESET,
    vdp_scandbl_ctrl_if.slave bus
);
    localparam logic [ADDR_W-1:0] LW = ADDR_W'(LINE_WIDTH);

    bank_sel_t         r_wr_bank, r_rd_bank, w_wr_bank_nxt, w_rd_bank_nxt, r_sel_p1;
    logic [ADDR_W-1:0] r_wr_cnt, r_rd_cnt, w_wr_addr, w_rd_addr;
    logic              w_wr_ok, w_rd_ok, w_rd_oor;
    logic              r_fetch_p1, r_oor_p1, r_ovf, r_q_vld;
    color_t            r_q_r, r_q_g, r_q_b;
    logic              w_we0, w_we1;
    store_t            w_b0_r, w_b0_g, w_b0_b, w_b1_r, w_b1_g, w_b1_b;

    // Start pulses act in the same cycle as a coincident strobe, so strobes use the post-start view.
    assign w_wr_bank_nxt = bus.WR_START ? ~r_wr_bank : r_wr_bank;
    assign w_wr_addr     = bus.WR_START ? '0 : r_wr_cnt;
    assign w_wr_ok       = bus.WR_EN && (w_wr_addr < LW);
    assign w_rd_bank_nxt = bus.RD_START ? ~w_wr_bank_nxt : r_rd_bank;
    assign w_rd_addr     = bus.RD_START ? '0 : r_rd_cnt;
    assign w_rd_ok       = bus.RD_EN && (w_rd_addr < LW);
    assign w_rd_oor      = bus.RD_EN && !w_rd_ok;
    assign w_we0         = w_wr_ok && (w_wr_bank_nxt == 1'b0);
    assign w_we1         = w_wr_ok && (w_wr_bank_nxt == 1'b1);

    vdp_scandbl_bank #(.LINE_WIDTH(LINE_WIDTH), .ADDR_W(ADDR_W)) u_bank0 (
        .i_clk(CLK21M), .i_we(w_we0), .i_wr_addr(w_wr_addr),
        .i_wr_r(pack_color(bus.DATA_R)), .i_wr_g(pack_color(bus.DATA_G)), .i_wr_b(pack_color(bus.DATA_B)),
        .i_re(w_rd_ok), .i_rd_addr(w_rd_addr),
        .o_rd_r(w_b0_r), .o_rd_g(w_b0_g), .o_rd_b(w_b0_b)
    );

    vdp_scandbl_bank #(.LINE_WIDTH(LINE_WIDTH), .ADDR_W(ADDR_W)) u_bank1 (
        .i_clk(CLK21M), .i_we(w_we1), .i_wr_addr(w_wr_addr),
        .i_wr_r(pack_color(bus.DATA_R)), .i_wr_g(pack_color(bus.DATA_G)), .i_wr_b(pack_color(bus.DATA_B)),
        .i_re(w_rd_ok), .i_rd_addr(w_rd_addr),
        .o_rd_r(w_b1_r), .o_rd_g(w_b1_g), .o_rd_b(w_b1_b)
    );

    always_ff @(posedge CLK21M) begin
        if (RESET) begin
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b1;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_ovf      <= 1'b0;
            r_fetch_p1 <= 1'b0;
            r_oor_p1   <= 1'b0;
            r_sel_p1   <= 1'b0;
            r_q_vld    <= 1'b0;
            r_q_r      <= '0;
            r_q_g      <= '0;
            r_q_b      <= '0;
        end else begin
            r_wr_bank  <= w_wr_bank_nxt;
            r_rd_bank  <= w_rd_bank_nxt;
            r_wr_cnt   <= w_wr_ok ? w_wr_addr + ADDR_W'(1) : w_wr_addr;
            r_rd_cnt   <= w_rd_ok ? w_rd_addr + ADDR_W'(1) : w_rd_addr;
            if (bus.WR_START) begin
                r_ovf <= 1'b0;
            end else if (bus.WR_EN && !w_wr_ok) begin
                r_ovf <= 1'b1;
            end
            r_fetch_p1 <= w_rd_ok;
            r_oor_p1   <= w_rd_oor;
            r_sel_p1   <= w_rd_bank_nxt;
            r_q_vld    <= r_fetch_p1;
            if (r_fetch_p1) begin
                r_q_r <= unpack_color(r_sel_p1 ? w_b1_r : w_b0_r);
                r_q_g <= unpack_color(r_sel_p1 ? w_b1_g : w_b0_g);
                r_q_b <= unpack_color(r_sel_p1 ? w_b1_b : w_b0_b);
            end else if (r_oor_p1) begin
                r_q_r <= '0;
                r_q_g <= '0;
                r_q_b <= '0;
            end
        end
    end

    assign bus.Q_R     = r_q_r;
    assign bus.Q_G     = r_q_g;
    assign bus.Q_B     = r_q_b;
    assign bus.Q_VALID = r_q_vld;
    assign bus.WR_OVF  = r_ovf;
endmodule

// File: tb/tb_vdp_scandbl_ctrl.sv
// Directed bench for vdp_scandbl_ctrl: line capture, doubled readout, overflow, coincident starts, reset.
module tb_vdp_scandbl_ctrl;
    import vdp_scandbl_pkg::*;

    localparam int LW = 640;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vdp_scandbl_ctrl_if bus();

    vdp_scandbl_ctrl dut (
        .CLK21M(clk),
        .RESET (rst),
        .bus   (bus)
    );

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Source pixel for a given test pattern and pixel index.
    function automatic color_t dsrc(input int mode, input int i);
        color_t v;
        v = 6'(i);
        case (mode)
            1:       return 6'h2A;
            2:       return 6'h15;
            3:       return ~v;
            4:       return (i == 0) ? 6'h3F : v;
            5:       return 6'(i + 7);
            default: return v;
        endcase
    endfunction

    function automatic color_t mask(input color_t c);
`ifdef VDP_SCANDBL_FULL_DEPTH_EN
        return c;
`else
        return c & 6'h3E;
`endif
    endfunction

    // Channels carry distinct values so swapped colour paths are visible.
    function automatic logic [31:0] exp_q(input color_t d);
        return {14'd0, mask(d), mask(d ^ 6'h3F), mask(6'(d + 6'd5))};
    endfunction

    function automatic logic [31:0] got_q();
        return {14'd0, bus.Q_R, bus.Q_G, bus.Q_B};
    endfunction

    task automatic drive_pix(input color_t d);
        bus.DATA_R = d;
        bus.DATA_G = d ^ 6'h3F;
        bus.DATA_B = 6'(d + 6'd5);
    endtask

    task automatic write_line(input int n, input int mode, input int first);
        for (int k = 0; k < n; k++) begin
            bus.WR_EN = 1'b1;
            drive_pix(dsrc(mode, first + k));
            tick();
        end
        bus.WR_EN = 1'b0;
    endtask

    // Streams n read strobes; fetch j is observed right after the edge that follows its strobe edge.
    task automatic read_line(input int n, input int mode, input bit rs, input bit ws);
        for (int i = 0; i <= n; i++) begin
            bus.RD_EN    = (i < n);
            bus.RD_START = rs && (i == 0);
            bus.WR_START = ws && (i == 0);
            tick();
            bus.RD_START = 1'b0;
            bus.WR_START = 1'b0;
            if (i >= 1) begin
                if (i - 1 < LW) begin
                    chk_vec($sformatf("m%0d_vld[%0d]", mode, i - 1), 32'(bus.Q_VALID), 32'd1);
                    chk_vec($sformatf("m%0d_q[%0d]", mode, i - 1), got_q(), exp_q(dsrc(mode, i - 1)));
                end else begin
                    chk_vec($sformatf("oor_vld[%0d]", i - 1), 32'(bus.Q_VALID), 32'd0);
                    chk_vec($sformatf("oor_q[%0d]", i - 1), got_q(), 32'd0);
                end
            end
        end
        bus.RD_EN = 1'b0;
        tick();
        chk_vec("idle_vld", 32'(bus.Q_VALID), 32'd0);
        chk_vec("idle_hold_q", got_q(), (n > LW) ? 32'd0 : exp_q(dsrc(mode, n - 1)));
    endtask

    task automatic pulse(input bit ws, input bit rs);
        bus.WR_START = ws;
        bus.RD_START = rs;
        tick();
        bus.WR_START = 1'b0;
        bus.RD_START = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk_vec({tag, "_vld"}, 32'(bus.Q_VALID), 32'd0);
        chk_vec({tag, "_q"}, got_q(), 32'd0);
        chk_vec({tag, "_ovf"}, 32'(bus.WR_OVF), 32'd0);
        chk_vec({tag, "_wr_bank"}, 32'(dut.r_wr_bank), 32'd0);
        chk_vec({tag, "_rd_bank"}, 32'(dut.r_rd_bank), 32'd1);
        chk_vec({tag, "_wr_cnt"}, 32'(dut.r_wr_cnt), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.WR_START = 1'b0;
        bus.WR_EN    = 1'b0;
        bus.RD_START = 1'b0;
        bus.RD_EN    = 1'b0;
        drive_pix(6'h00);
        repeat (3) tick();
        chk_reset_state("rst");
        rst = 1'b0;

        // Ramp line, then swap and read it back.
        pulse(1'b1, 1'b0);
        write_line(LW, 0, 0);
        pulse(1'b1, 1'b1);
        read_line(LW, 0, 1'b0, 1'b0);

        // Line A captured, line B captured while A is shown twice, then B shown twice.
        write_line(LW, 1, 0);
        pulse(1'b1, 1'b1);
        write_line(LW, 2, 0);
        read_line(LW, 1, 1'b0, 1'b0);
        read_line(LW, 1, 1'b1, 1'b0);
        read_line(LW, 2, 1'b1, 1'b1);
        read_line(LW, 2, 1'b1, 1'b0);

        // Write overflow and read overrun.
        write_line(LW, 3, 0);
        chk_vec("ovf_at_640", 32'(bus.WR_OVF), 32'd0);
        write_line(1, 3, LW);
        chk_vec("ovf_at_641", 32'(bus.WR_OVF), 32'd1);
        write_line(1, 3, LW + 1);
        chk_vec("ovf_at_642", 32'(bus.WR_OVF), 32'd1);
        chk_vec("wr_cnt_hold", 32'(dut.r_wr_cnt), 32'(LW));
        read_line(LW + 5, 3, 1'b1, 1'b1);
        chk_vec("ovf_cleared", 32'(bus.WR_OVF), 32'd0);
        chk_vec("rd_cnt_hold", 32'(dut.r_rd_cnt), 32'(LW));

        // Coincident WR_START+WR_EN, then coincident RD_START+RD_EN.
        bus.WR_START = 1'b1;
        bus.WR_EN    = 1'b1;
        drive_pix(dsrc(4, 0));
        tick();
        bus.WR_START = 1'b0;
        bus.WR_EN    = 1'b0;
        chk_vec("coinc_wr_cnt", 32'(dut.r_wr_cnt), 32'd1);
        write_line(LW - 1, 4, 1);
        read_line(LW, 4, 1'b1, 1'b1);

        // Reset in the middle of a capture.
        write_line(300, 5, 0);
        rst       = 1'b1;
        bus.WR_EN = 1'b1;
        drive_pix(dsrc(5, 300));
        tick();
        rst       = 1'b0;
        bus.WR_EN = 1'b0;
        chk_reset_state("midrst");
        pulse(1'b1, 1'b0);
        write_line(LW, 5, 0);
        pulse(1'b1, 1'b1);
        read_line(LW, 5, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
